// File: rtl/iq_avg_snapshot_sequencer.sv
// Control sequencer for one IQ-average snapshot: arm, wait for frame sync,
// accumulate 2^avg_log2 frames, then stream one averaged frame to the snapshot BRAM.
module iq_avg_snapshot_sequencer #(
    parameter int unsigned N_CHAN_BITS  = 8,
    parameter int unsigned AVG_LOG2_MAX = 10
) (
    input  logic                   user_clk,
    input  logic                   user_rst,
    input  logic [31:0]            ctrl_word,
    input  logic                   sync_in,
    output logic                   acc_en,
    output logic                   acc_first,
    output logic [3:0]             avg_shift,
    output logic                   ss_we,
    output logic [N_CHAN_BITS-1:0] ss_addr,
    output logic                   busy,
    output logic                   done,
    output logic [31:0]            status
);

    localparam int unsigned FRAME_W = 12;
    localparam int unsigned AVG_W   = 4;
    localparam logic [N_CHAN_BITS-1:0] ADDR_LAST = '1;
    localparam logic [AVG_W-1:0]       AVG_MAX   = AVG_W'(AVG_LOG2_MAX);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_SYNC = 3'd1,
        S_ACCUM     = 3'd2,
        S_DUMP      = 3'd3,
        S_DONE      = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic                   arm_q;
    logic [AVG_W-1:0]       avg_q, avg_d;
    logic [FRAME_W-1:0]     frame_cnt_q, frame_cnt_d;
    logic                   sync_err_q, sync_err_d;
    logic                   acc_en_q, acc_en_d;
    logic                   acc_first_q, acc_first_d;
    logic                   ss_we_q, ss_we_d;
    logic [N_CHAN_BITS-1:0] ss_addr_q, ss_addr_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   arm_edge;
    logic                   abort;
    logic [AVG_W-1:0]       req_avg;
    logic [FRAME_W-1:0]     frame_last;
    logic                   unused_ctrl;

    assign arm_edge    = ctrl_word[0] & ~arm_q;
    assign abort       = ctrl_word[1];
    assign req_avg     = ctrl_word[5:2];
    assign frame_last  = FRAME_W'((32'd1 << avg_q) - 32'd1);
    assign unused_ctrl = ^ctrl_word[31:6];

    // State and registered outputs
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            state_q     <= S_IDLE;
            arm_q       <= 1'b0;
            avg_q       <= '0;
            frame_cnt_q <= '0;
            sync_err_q  <= 1'b0;
            acc_en_q    <= 1'b0;
            acc_first_q <= 1'b0;
            ss_we_q     <= 1'b0;
            ss_addr_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            arm_q       <= ctrl_word[0];
            avg_q       <= avg_d;
            frame_cnt_q <= frame_cnt_d;
            sync_err_q  <= sync_err_d;
            acc_en_q    <= acc_en_d;
            acc_first_q <= acc_first_d;
            ss_we_q     <= ss_we_d;
            ss_addr_q   <= ss_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic; output flops are decoded from the next state
    always_comb begin
        state_d     = state_q;
        avg_d       = avg_q;
        frame_cnt_d = frame_cnt_q;
        sync_err_d  = sync_err_q;
        acc_first_d = acc_first_q;
        ss_addr_d   = ss_addr_q;

        if (abort) begin
            state_d     = S_IDLE;
            acc_first_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (arm_edge) begin
                        avg_d       = (req_avg > AVG_MAX) ? AVG_MAX : req_avg;
                        frame_cnt_d = '0;
                        sync_err_d  = 1'b0;
                        state_d     = S_WAIT_SYNC;
                    end
                end
                S_WAIT_SYNC: begin
                    if (sync_in) begin
                        state_d     = S_ACCUM;
                        ss_addr_d   = '0;
                        acc_first_d = 1'b1;
                    end
                end
                S_ACCUM: begin
                    // Final frame boundary leaves frame_cnt at 2^avg_log2 - 1
                    if (sync_in) begin
                        if (frame_cnt_q == frame_last) begin
                            state_d     = S_DUMP;
                            ss_addr_d   = '0;
                            acc_first_d = 1'b0;
                        end else begin
                            frame_cnt_d = frame_cnt_q + 1'b1;
                            acc_first_d = 1'b0;
                        end
                    end
                end
                S_DUMP: begin
                    if (sync_in) begin
                        sync_err_d = 1'b1;
                    end
                    ss_addr_d = ss_addr_q + 1'b1;
                    if (ss_addr_q == ADDR_LAST) begin
                        state_d = S_DONE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        acc_en_d = (state_d == S_ACCUM);
        ss_we_d  = (state_d == S_DUMP);
        busy_d   = (state_d == S_WAIT_SYNC) || (state_d == S_ACCUM) || (state_d == S_DUMP);
        done_d   = (state_d == S_DONE);
        if (state_d != S_ACCUM) begin
            acc_first_d = 1'b0;
        end
    end

    assign acc_en    = acc_en_q;
    assign acc_first = acc_first_q;
    assign avg_shift = avg_q;
    assign ss_we     = ss_we_q;
    assign ss_addr   = ss_addr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign status    = {16'h0000, frame_cnt_q, sync_err_q, state_q};

endmodule

// File: tb/tb_iq_avg_snapshot_sequencer.sv
// Directed bench for iq_avg_snapshot_sequencer with a cycle-level reference model
// and literal checks on capture lengths, addresses and status words.
module tb_iq_avg_snapshot_sequencer;

    localparam int NCB   = 4;
    localparam int AMAX  = 3;
    localparam int FRAME = 1 << NCB;

    bit               clk = 1'b0;
    logic             user_rst;
    logic [31:0]      ctrl_word;
    logic             sync_in;
    logic             acc_en;
    logic             acc_first;
    logic [3:0]       avg_shift;
    logic             ss_we;
    logic [NCB-1:0]   ss_addr;
    logic             busy;
    logic             done;
    logic [31:0]      status;

    iq_avg_snapshot_sequencer #(
        .N_CHAN_BITS (NCB),
        .AVG_LOG2_MAX(AMAX)
    ) dut (
        .user_clk (clk),
        .user_rst (user_rst),
        .ctrl_word(ctrl_word),
        .sync_in  (sync_in),
        .acc_en   (acc_en),
        .acc_first(acc_first),
        .avg_shift(avg_shift),
        .ss_we    (ss_we),
        .ss_addr  (ss_addr),
        .busy     (busy),
        .done     (done),
        .status   (status)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int sync_phase = 0;
    bit sync_en    = 1'b0;
    bit inject     = 1'b0;

    // Reference model: phase code 0 idle, 1 wait sync, 2 accumulate, 3 dump, 4 done
    int          m_code     = 0;
    int unsigned m_avg      = 0;
    int unsigned m_frames   = 0;
    int unsigned m_dump     = 0;
    bit          m_err      = 1'b0;
    bit          m_arm_prev = 1'b0;

    int n_acc = 0, n_first = 0, n_we = 0, n_busy = 0;
    int b_acc = 0, b_first = 0, b_we = 0, b_busy = 0;
    int we_first = -1, we_last = -1;
    bit we_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit edge_seen;
        edge_seen  = ctrl_word[0] && !m_arm_prev;
        m_arm_prev = ctrl_word[0];
        if (user_rst) begin
            m_code = 0; m_avg = 0; m_frames = 0; m_dump = 0; m_err = 1'b0; m_arm_prev = 1'b0;
        end else if (ctrl_word[1]) begin
            m_code = 0;
        end else begin
            case (m_code)
                0, 4: if (edge_seen) begin
                    m_avg    = (ctrl_word[5:2] > AMAX) ? AMAX : ctrl_word[5:2];
                    m_frames = 0;
                    m_err    = 1'b0;
                    m_code   = 1;
                end
                1: if (sync_in) m_code = 2;
                2: if (sync_in) begin
                    if (m_frames + 1 == (1 << m_avg)) begin
                        m_code = 3;
                        m_dump = 0;
                    end else begin
                        m_frames++;
                    end
                end
                3: begin
                    if (sync_in) m_err = 1'b1;
                    if (m_dump == FRAME - 1) m_code = 4;
                    else m_dump++;
                end
                default: m_code = 0;
            endcase
        end
    endtask

    task automatic compare();
        logic [31:0] e_status;
        logic [31:0] fr;
        logic [31:0] cd;
        fr = m_frames;
        cd = m_code;
        e_status = {16'h0000, fr[11:0], m_err, cd[2:0]};
        chk("acc_en",    32'(acc_en),    32'(m_code == 2));
        chk("acc_first", 32'(acc_first), 32'(m_code == 2 && m_frames == 0));
        chk("ss_we",     32'(ss_we),     32'(m_code == 3));
        chk("busy",      32'(busy),      32'(m_code >= 1 && m_code <= 3));
        chk("done",      32'(done),      32'(m_code == 4));
        chk("avg_shift", 32'(avg_shift), m_avg);
        chk("status",    status,         e_status);
        if (m_code == 3) chk("ss_addr", 32'(ss_addr), m_dump);
    endtask

    // One clock: drive inputs, let the edge happen, update model, compare mid-cycle
    task automatic tick();
        sync_in    = (sync_en && sync_phase == 0) || inject;
        inject     = 1'b0;
        sync_phase = (sync_phase + 1) % FRAME;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
        if (m_code == 3) sync_en = 1'b0;
        if (acc_en === 1'b1)    n_acc++;
        if (acc_first === 1'b1) n_first++;
        if (busy === 1'b1)      n_busy++;
        if (ss_we === 1'b1) begin
            n_we++;
            if (!we_prev) we_first = int'(ss_addr);
            we_last = int'(ss_addr);
        end
        we_prev = (ss_we === 1'b1);
    endtask

    task automatic snap();
        b_acc = n_acc; b_first = n_first; b_we = n_we; b_busy = n_busy;
    endtask

    task automatic run_to_done(input int budget);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        if (done !== 1'b1) chk("done_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        int n;
        user_rst  = 1'b1;
        ctrl_word = 32'h0;
        sync_in   = 1'b0;
        repeat (3) tick();
        chk("rst_status", status, 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_avg_shift", 32'(avg_shift), 32'd0);
        user_rst = 1'b0;
        tick();

        // Basic capture, avg_log2 = 2
        snap();
        ctrl_word = 32'h9; sync_en = 1'b1;
        tick();
        chk("basic_busy_latency", 32'(busy), 32'd1);
        run_to_done(400);
        chk("basic_acc_en_cycles", n_acc - b_acc, 32'd64);
        chk("basic_acc_first_cycles", n_first - b_first, 32'd16);
        chk("basic_we_cycles", n_we - b_we, 32'd16);
        chk("basic_first_addr", we_first, 32'd0);
        chk("basic_last_addr", we_last, 32'd15);
        chk("basic_status", status, 32'h34);
        chk("basic_avg_shift", 32'(avg_shift), 32'd2);

        // Clamp: request 15, limited to 3
        ctrl_word = 32'h0; tick();
        snap();
        ctrl_word = 32'h3D; sync_en = 1'b1;
        tick();
        run_to_done(600);
        chk("clamp_avg_shift", 32'(avg_shift), 32'd3);
        chk("clamp_acc_en_cycles", n_acc - b_acc, 32'd128);
        chk("clamp_status", status, 32'h74);

        // Abort during the second frame
        ctrl_word = 32'h0; tick();
        ctrl_word = 32'h9; sync_en = 1'b1;
        tick();
        n = 0;
        while (status[15:4] == 12'd0 && n < 200) begin tick(); n++; end
        repeat (3) tick();
        ctrl_word = 32'h2;
        tick();
        chk("abort_acc_en", 32'(acc_en), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_state", 32'(status[2:0]), 32'd0);
        ctrl_word = 32'h0; tick();
        snap();
        ctrl_word = 32'h9; sync_en = 1'b1;
        tick();
        run_to_done(400);
        chk("rearm_acc_en_cycles", n_acc - b_acc, 32'd64);
        chk("rearm_we_cycles", n_we - b_we, 32'd16);
        chk("rearm_status", status, 32'h34);

        // Extra sync while dumping at address 5
        ctrl_word = 32'h0; tick();
        snap();
        ctrl_word = 32'h9; sync_en = 1'b1;
        tick();
        n = 0;
        while (!(ss_we === 1'b1 && ss_addr == 4'd5) && n < 300) begin tick(); n++; end
        chk("glitch_addr5_reached", 32'(ss_we === 1'b1 && ss_addr == 4'd5), 32'd1);
        inject = 1'b1;
        run_to_done(100);
        chk("glitch_we_cycles", n_we - b_we, 32'd16);
        chk("glitch_last_addr", we_last, 32'd15);
        chk("glitch_status", status, 32'h3C);
        ctrl_word = 32'h0; tick();
        ctrl_word = 32'h9; sync_en = 1'b1;
        tick();
        chk("rearm_clears_err", 32'(status[3]), 32'd0);

        // Arm held high across DONE gives only one capture
        run_to_done(400);
        snap();
        repeat (40) tick();
        chk("held_no_busy", n_busy - b_busy, 32'd0);
        chk("held_done", 32'(done), 32'd1);
        ctrl_word = 32'h0; tick();
        ctrl_word = 32'h9; sync_en = 1'b1;
        tick();
        chk("held_rearm_busy", 32'(busy), 32'd1);
        ctrl_word = 32'h2; tick();
        ctrl_word = 32'h0; tick();

        // Arm edge coincident with sync: wait for the following sync
        sync_en = 1'b1;
        n = 0;
        while (sync_phase != 0 && n < 40) begin tick(); n++; end
        snap();
        ctrl_word = 32'h1;
        tick();
        chk("coinc_busy", 32'(busy), 32'd1);
        chk("coinc_no_acc", 32'(acc_en), 32'd0);
        n = 0;
        while (acc_en !== 1'b1 && n < 40) begin tick(); n++; end
        chk("coinc_accum_delay", n, 32'd16);
        run_to_done(100);
        chk("coinc_acc_en_cycles", n_acc - b_acc, 32'd16);
        chk("coinc_acc_first_cycles", n_first - b_first, 32'd16);
        chk("coinc_status", status, 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/iq_avg_snapshot_sequencer.md
# iq_avg_snapshot_sequencer

- Sequences one IQ-average snapshot capture, driven by the ppc2simulink control word of the IQ averager snapshot.
- Flow: software sets an arm bit; the block waits for the next frame sync, accumulates 2^avg_log2 frames, then streams one frame of averaged IQ into the snapshot BRAM.
- Reports progress in a status word read back over the bus.
- Sits in the user_clk domain between the control register and the accumulator/snapshot datapath.

## Interface

Parameters:
- N_CHAN_BITS, 8, log2 of cycles per frame (channels per sync period); snapshot depth is 2^N_CHAN_BITS.
- AVG_LOG2_MAX, 10, upper clamp on requested avg_log2.

Ports:
- user_clk  in  1  clock.
- user_rst  in  1  synchronous active-high reset.
- ctrl_word  in  32  control register value:
  - [0] arm, rising-edge triggered.
  - [1] abort, level.
  - [5:2] avg_log2.
- sync_in  in  1  one-cycle frame-start pulse from the channelizer.
- acc_en  out  1  accumulator add enable.
- acc_first  out  1  write-instead-of-add, first frame only.
- avg_shift  out  4  right-shift applied by the datapath at readout; equals latched avg_log2.
- ss_we  out  1  snapshot BRAM write enable.
- ss_addr  out  N_CHAN_BITS  snapshot BRAM write address.
- busy  out  1  high in WAIT_SYNC, ACCUM, DUMP.
- done  out  1  high in DONE.
- status  out  32  readback word:
  - [2:0] state code.
  - [3] sync_err.
  - [15:4] frame_cnt, zero-extended.
  - [31:16] 0.

## Operation

- **State encoding:** IDLE=0, WAIT_SYNC=1, ACCUM=2, DUMP=3, DONE=4.
- **Arm detection:** arm_q registers ctrl_word[0]; arm_edge = ctrl_word[0] & ~arm_q.
- **Abort:** ctrl_word[1]=1 forces IDLE on the next edge from any state.
  - Clears acc_en, acc_first, ss_we and done.
  - Abort has priority over arm_edge and sync_in.
- **IDLE / DONE:** on arm_edge:
  - latch avg_log2 = min(ctrl_word[5:2], AVG_LOG2_MAX);
  - clear frame_cnt and sync_err;
  - go to WAIT_SYNC.
  - arm_edge in any other state is ignored.
- **WAIT_SYNC:** on sync_in, go to ACCUM and zero the channel counter.
  - A sync_in in the same cycle as the arm_edge that left IDLE is ignored; the block waits for the next sync.
- **ACCUM:**
  - acc_en=1 every cycle.
  - acc_first=1 until the first sync_in after entry.
  - Each sync_in increments frame_cnt (12-bit).
  - On the sync_in where frame_cnt == 2^avg_log2 − 1, go to DUMP instead of incrementing; ss_addr=0.
  - avg_log2=0 therefore gives one frame, and acc_first stays high for all of it.
- **DUMP:**
  - ss_we=1, acc_en=0.
  - ss_addr increments every cycle from 0 to 2^N_CHAN_BITS − 1, then goes to DONE.
  - A sync_in during DUMP sets sticky sync_err but does not shorten or restart the dump.
- **DONE:** done=1; holds until arm_edge (re-arm) or abort.
- **avg_shift:** always reflects the latched avg_log2.

## Timing

- Reset values: state=IDLE, arm_q=0, acc_en=0, acc_first=0, ss_we=0, ss_addr=0, busy=0, done=0, sync_err=0, frame_cnt=0, avg_shift=0, status=0.
- All outputs are registered, so the effect of an input at edge t is visible after edge t+1.
- **Arm latency:** ctrl_word[0] rises at cycle t → busy=1 at t+1.
- **Accumulate start:** sync_in at t in WAIT_SYNC → acc_en=acc_first=1 at t+1.
- **Accumulate length:** exactly 2^avg_log2 × frame period, provided syncs are periodic.
- **Dump start:** the final sync_in at t → acc_en=0, ss_we=1, ss_addr=0 at t+1.
- **Dump window:** ss_we is high for exactly 2^N_CHAN_BITS consecutive cycles; done=1 the cycle after the last write.
- **Counter widths:** ss_addr wraps naturally at 2^N_CHAN_BITS, but the FSM leaves DUMP on the last address, so no second pass occurs.
- **Level-held arm:** holding arm high produces a single capture; a new capture requires arm to go low then high.

## Test plan

All scenarios use N_CHAN_BITS=4 (16-cycle sync period) unless noted.

- **Basic capture:** reset, then ctrl_word=0x9 (arm, avg_log2=2) → busy next cycle; acc_first for 16 cycles; acc_en for 64 cycles; ss_we for 16 cycles with ss_addr 0..15; done=1; status[2:0]=4.
- **Clamp:** with AVG_LOG2_MAX=3 and avg_log2=15 requested → avg_shift=3, accumulation of 128 cycles.
- **Abort mid-ACCUM:** set ctrl_word[1]=1 during the 2nd frame → IDLE next cycle with acc_en=0, busy=0, done=0. Clearing abort and re-arming yields a full clean capture.
- **Sync glitch during DUMP:** inject an extra sync at ss_addr=5 → dump still runs to addr 15; status[3]=1; the next arm clears status[3].
- **Level-held arm:** hold arm high through DONE → no second capture. Drop arm, raise it again → a new capture starts.
- **Coincident arm and sync:** arm edge and sync_in in the same cycle → remain in WAIT_SYNC; ACCUM begins only after the next sync.
